// File: rtl/counter_param_hex_pkg.sv
// ---------------------------------------------------------------------------
// counter_param_hex_pkg
//   Shared constants and helpers for the parametrised hex-display counter.
//   - SEG_CODES : active-low seven-segment patterns for nibble 0..F,
//                 bit 0 = segment a, bit 6 = segment g.
//   - clog2_min1: ceil(log2(v)) clamped to at least 1, used to size the
//                 prescaler so a PRESCALE of 1 still gets a legal 1-bit reg.
// ---------------------------------------------------------------------------
package counter_param_hex_pkg;

    localparam logic [6:0] SEG_CODES [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h18, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    // Bounded loop keeps this a plain constant function for elaboration.
    function automatic int clog2_min1(input longint unsigned v);
        int r;
        r = 0;
        for (int i = 0; i < 63; i++) begin
            if ((64'd1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/counter_param_hex_if.sv
// ---------------------------------------------------------------------------
// counter_param_hex_if
//   Control / display bundle between the board switches/keys and the counter.
//   master : board side  - drives enable, up, load, load_value;
//                          receives count (LEDR), tc, hex (HEX displays).
//   slave  : counter side - the reverse.
//   clock and resetb are kept outside the bundle as plain ports.
// ---------------------------------------------------------------------------
interface counter_param_hex_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = (WIDTH + 3) / 4
);
    logic                  enable;
    logic                  up;
    logic                  load;
    logic [WIDTH-1:0]      load_value;
    logic [WIDTH-1:0]      count;
    logic                  tc;
    logic [7*DIGITS-1:0]   hex;

    modport master (
        output enable, up, load, load_value,
        input  count, tc, hex
    );

    modport slave (
        input  enable, up, load, load_value,
        output count, tc, hex
    );
endinterface

// File: rtl/counter_param_hex_hex_digit_decode.sv
// ---------------------------------------------------------------------------
// hex_digit_decode
//   Pure combinational nibble -> active-low seven-segment decoder.
//   i_nib : 4-bit value to display
//   o_seg : segments {g,f,e,d,c,b,a}, 0 = lit
// ---------------------------------------------------------------------------
module hex_digit_decode
    import counter_param_hex_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);
    assign o_seg = SEG_CODES[i_nib];
endmodule

// File: rtl/counter_param_hex.sv
// ---------------------------------------------------------------------------
// counter_param_hex
//   Modulo-MODULUS up/down counter with synchronous load, enable-gated
//   prescaler, wrap/saturate boundary handling, a registered terminal-count
//   pulse and DIGITS seven-segment display drivers.
//
//   clock  : system clock, everything updates on its rising edge
//   resetb : synchronous active-low reset
//   bus    : slave side of counter_param_hex_if
//            enable, up, load, load_value in; count, tc, hex out
//
//   Edge priority: reset > load > step > hold.
// ---------------------------------------------------------------------------
module counter_param_hex
    import counter_param_hex_pkg::*;
#(
    parameter int      WIDTH    = 8,
    parameter longint  MODULUS  = 256,
    parameter int      PRESCALE = 1,
    parameter bit      SATURATE = 1'b0,
    parameter int      DIGITS   = (WIDTH + 3) / 4
) (
    input  logic                 clock,
    input  logic                 resetb,
    counter_param_hex_if.slave   bus
);

    localparam int              PS_W    = clog2_min1(longint'(PRESCALE));
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE - 1);
    localparam int              NIB_W   = 4 * DIGITS;

    // Elaboration-time sanity checks on the parameter ranges.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("counter_param_hex: WIDTH out of range");
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_mod
        $error("counter_param_hex: MODULUS out of range");
    end
    if (PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_ps
        $error("counter_param_hex: PRESCALE out of range");
    end

    logic [WIDTH-1:0] r_count;
    logic [PS_W-1:0]  r_pre;
    logic             r_tc;

    logic             w_step;
    logic             w_at_top;
    logic             w_at_bot;
    logic             w_boundary;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load_clamp;

    // A step fires on the enabled edge where the prescaler is at its last
    // phase; with PRESCALE = 1 PS_LAST is 0 and r_pre never leaves 0.
    assign w_step   = bus.enable && (r_pre == PS_LAST);
    assign w_at_top = (r_count == MAX_VAL);
    assign w_at_bot = (r_count == '0);

    assign w_load_clamp = (bus.load_value > MAX_VAL) ? MAX_VAL : bus.load_value;

    // Next value of a step. Wrapping goes to the modulus bounds, never the
    // natural 2**WIDTH rollover, so non-power-of-two moduli work.
    always_comb begin
        w_next     = r_count;
        w_boundary = 1'b0;
        if (bus.up) begin
            if (w_at_top) begin
                w_boundary = 1'b1;
                w_next     = SATURATE ? r_count : '0;
            end else begin
                w_next     = r_count + WIDTH'(1);
            end
        end else begin
            if (w_at_bot) begin
                w_boundary = 1'b1;
                w_next     = SATURATE ? r_count : MAX_VAL;
            end else begin
                w_next     = r_count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            r_count <= '0;
            r_pre   <= '0;
            r_tc    <= 1'b0;
        end else if (bus.load) begin
            r_count <= w_load_clamp;
            r_pre   <= '0;
            r_tc    <= 1'b0;
        end else if (bus.enable) begin
            r_pre <= w_step ? '0 : r_pre + PS_W'(1);
            if (w_step) begin
                r_count <= w_next;
                r_tc    <= w_boundary;
            end else begin
                r_tc    <= 1'b0;
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign bus.count = r_count;
    assign bus.tc    = r_tc;

    // Zero-extend (or truncate) the count to whole nibbles for the digits.
    logic [NIB_W-1:0]    w_nib_ext;
    logic [7*DIGITS-1:0] w_hex;

    assign w_nib_ext = NIB_W'(r_count);

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        hex_digit_decode u_dig (
            .i_nib (w_nib_ext[4*k +: 4]),
            .o_seg (w_hex[7*k +: 7])
        );
    end

    assign bus.hex = w_hex;

endmodule
